// File: rtl/encoder_4x2_seq_if.sv
// Request/grant bus for encoder_4x2_seq: request pulses and ack in, code/valid/status out.
interface encoder_4x2_seq_if #(
    parameter int unsigned W = 2
);
    localparam int unsigned N = 1 << W;

    logic         e;
    logic [N-1:0] d;
    logic         ack;
    logic [W-1:0] q;
    logic         v;
    logic         err;
    logic [N-1:0] pend;

    modport master (output e, d, ack, input q, v, err, pend);
    modport slave  (input e, d, ack, output q, v, err, pend);
endinterface

// File: rtl/encoder_4x2_seq.sv
// Registered priority encoder with pending-request capture, ack handshake and hold timeout.
// Define ENC_RR_EN for round-robin selection; default is fixed highest-index priority.
module encoder_4x2_seq #(
    parameter int unsigned W  = 2,
    parameter int unsigned TO = 15
) (
    input logic              clk,
    input logic              rst,
    encoder_4x2_seq_if.slave bus
);
    localparam int unsigned N     = 1 << W;
    localparam logic [7:0]  TO_M1 = 8'(TO - 1);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] q_q, q_d;
    logic [7:0]   timer_q, timer_d;
    logic [N-1:0] pend_q, pend_d;
    logic         err_q, err_d;
    logic [N-1:0] clr;
    logic         acked, timeout;
    logic [W-1:0] pick_idle, pick_next;

`ifdef ENC_RR_EN
    logic [W-1:0] lp_q, lp_d;

    // Scan downward from lp-1, wrapping; i == N lands back on lp itself.
    function automatic logic [W-1:0] sel_rr(input logic [N-1:0] p, input logic [W-1:0] lp);
        logic [W-1:0] sel;
        logic [W-1:0] idx;
        logic         found;
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= int'(N); i++) begin
            idx = lp - W'(i);
            if (!found && p[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction
`else
    function automatic logic [W-1:0] sel_fixed(input logic [N-1:0] p);
        logic [W-1:0] sel;
        sel = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (p[i]) sel = W'(i);
        end
        return sel;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        timer_d = timer_q;
        err_d   = 1'b0;
        clr     = '0;

        acked   = (state_q == StHold) && bus.ack;
        timeout = (state_q == StHold) && !bus.ack && (timer_q == TO_M1);

        if (acked || timeout) clr = {{(N-1){1'b0}}, 1'b1} << q_q;
        // A bit cleared and re-requested in the same cycle stays set.
        pend_d = (pend_q & ~clr) | (bus.e ? bus.d : '0);

`ifdef ENC_RR_EN
        lp_d = lp_q;
        if (acked || timeout) lp_d = q_q;
        pick_idle = sel_rr(pend_q, lp_d);
        pick_next = sel_rr(pend_d, lp_d);
`else
        pick_idle = sel_fixed(pend_q);
        pick_next = sel_fixed(pend_d);
`endif

        unique case (state_q)
            StIdle: begin
                if (pend_q != '0) begin
                    q_d     = pick_idle;
                    timer_d = '0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (acked) begin
                    timer_d = '0;
                    if (pend_d != '0) q_d = pick_next;
                    else state_d = StIdle;
                end else if (timeout) begin
                    timer_d = '0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            q_q     <= '0;
            timer_q <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
`ifdef ENC_RR_EN
            lp_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
`ifdef ENC_RR_EN
            lp_q    <= lp_d;
`endif
        end
    end

    assign bus.q    = q_q;
    assign bus.v    = (state_q == StHold);
    assign bus.err  = err_q;
    assign bus.pend = pend_q;
endmodule
